// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-condition encodings, opcodes, fetch FSM states.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [2:0] BR_NE  = 3'd0;
  localparam logic [2:0] BR_GTZ = 3'd1;
  localparam logic [2:0] BR_LEZ = 3'd2;
  localparam logic [2:0] BR_EQ  = 3'd3;
  localparam logic [2:0] BR_LTZ = 3'd4;
  localparam logic [2:0] BR_GEZ = 3'd5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  typedef enum logic [1:0] {BOOT, FETCH, FULL, DRAIN} fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Resolves taken/redirect and the redirect target from decoder controls and ALU flags.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic        res_valid_i,
  input  logic [31:0] res_pc_i,
  input  logic        res_jump_i,
  input  logic        res_jumpr_i,
  input  logic        res_branch_i,
  input  logic [2:0]  res_branch_st_i,
  input  logic [15:0] res_imm16_i,
  input  logic [25:0] res_jidx_i,
  input  logic [31:0] res_rs_i,
  input  logic        alu_zero_i,
  input  logic        alu_neg_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        addr_err_o
);

  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;

  assign pc_plus4 = res_pc_i + 32'd4;
  assign br_off   = {{14{res_imm16_i[15]}}, res_imm16_i, 2'b00};

  always_comb begin
    taken = 1'b0;
    case (res_branch_st_i)
      BR_NE:   taken = !alu_zero_i;
      BR_GTZ:  taken = !alu_zero_i && !alu_neg_i;
      BR_LEZ:  taken = alu_zero_i || alu_neg_i;
      BR_EQ:   taken = alu_zero_i;
      BR_LTZ:  taken = alu_neg_i;
      BR_GEZ:  taken = !alu_neg_i;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target_o = pc_plus4 + br_off;
    if (res_jumpr_i)     target_o = {res_rs_i[31:2], 2'b00};
    else if (res_jump_i) target_o = {pc_plus4[31:28], res_jidx_i, 2'b00};
  end

  assign redirect_o = res_valid_i && (res_jumpr_i || res_jump_i || (res_branch_i && taken));
  assign addr_err_o = res_valid_i && res_jumpr_i && (res_rs_i[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem req/ready handshake, one-entry instruction register, redirect/flush.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [5:0]  if_opcode,
  output logic [5:0]  if_funct,
  output logic [4:0]  if_rt,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_jump,
  input  logic        res_jumpr,
  input  logic        res_branch,
  input  logic [2:0]  res_branch_st,
  input  logic [15:0] res_imm16,
  input  logic [25:0] res_jidx,
  input  logic [31:0] res_rs,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic        redirect,
  output logic        addr_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ifpc_q, ifpc_d;
  logic         addr_err_q;
  logic [31:0]  target;
  logic         jr_misaligned;

  next_pc_calc u_npc (
    .res_valid_i     (res_valid),
    .res_pc_i        (res_pc),
    .res_jump_i      (res_jump),
    .res_jumpr_i     (res_jumpr),
    .res_branch_i    (res_branch),
    .res_branch_st_i (res_branch_st),
    .res_imm16_i     (res_imm16),
    .res_jidx_i      (res_jidx),
    .res_rs_i        (res_rs),
    .alu_zero_i      (alu_zero),
    .alu_neg_i       (alu_neg),
    .redirect_o      (redirect),
    .target_o        (target),
    .addr_err_o      (jr_misaligned)
  );

  // A redirect overrides every other transition; pc always follows the latest target.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    if (redirect) pc_d = target;
    case (state_q)
      BOOT: begin
        state_d    = FETCH;
        req_addr_d = redirect ? target : pc_q;
      end
      FETCH: begin
        if (redirect) begin
          if (imem_ready) req_addr_d = target;
          else            state_d    = DRAIN;
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          ifpc_d  = req_addr_q;
          pc_d    = req_addr_q + 32'd4;
          state_d = FULL;
        end
      end
      FULL: begin
        if (redirect) begin
          req_addr_d = target;
          state_d    = FETCH;
        end else if (if_ready) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ready) begin
          req_addr_d = redirect ? target : pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= '0;
      ifpc_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      addr_err_q <= jr_misaligned;
    end
  end

  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = req_addr_q;
  assign if_valid  = (state_q == FULL);
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign if_opcode = instr_q[31:26];
  assign if_funct  = instr_q[5:0];
  assign if_rt     = instr_q[20:16];
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: fetch stream, stalls, redirects, drain and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [5:0]  if_opcode;
  logic [5:0]  if_funct;
  logic [4:0]  if_rt;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_jump;
  logic        res_jumpr;
  logic        res_branch;
  logic [2:0]  res_branch_st;
  logic [15:0] res_imm16;
  logic [25:0] res_jidx;
  logic [31:0] res_rs;
  logic        alu_zero;
  logic        alu_neg;
  logic        redirect;
  logic        addr_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];
  logic [31:0] exp_addr_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_opcode(if_opcode), .if_funct(if_funct), .if_rt(if_rt),
    .res_valid(res_valid), .res_pc(res_pc), .res_jump(res_jump), .res_jumpr(res_jumpr),
    .res_branch(res_branch), .res_branch_st(res_branch_st), .res_imm16(res_imm16),
    .res_jidx(res_jidx), .res_rs(res_rs), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .redirect(redirect), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hAC00_5A5A;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic drive_idle;
    res_valid = 0; res_pc = 0; res_jump = 0; res_jumpr = 0; res_branch = 0;
    res_branch_st = 0; res_imm16 = 0; res_jidx = 0; res_rs = 0; alu_zero = 0; alu_neg = 0;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_ins_q.push_back(mem_word(pc));
  endtask

  task automatic test_reset;
    logic exp_taken;
    rst_n = 0; imem_ready = 0; if_ready = 0; drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: req=%b valid=%b aerr=%b want 0 0 0", imem_req, if_valid, addr_err);
    end
    n_tests++;
    if (if_instr !== 32'h0 || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_ir: instr=%h pc=%h want 0 0", if_instr, if_pc);
    end
    // Condition table exercised while held in reset, so redirects cannot disturb state.
    for (int st = 0; st < 8; st++) begin
      for (int zn = 0; zn < 4; zn++) begin
        res_valid = 1; res_branch = 1; res_branch_st = 3'(st);
        alu_zero = zn[0]; alu_neg = zn[1];
        case (st)
          0: exp_taken = !alu_zero;
          1: exp_taken = !alu_zero && !alu_neg;
          2: exp_taken = alu_zero || alu_neg;
          3: exp_taken = alu_zero;
          4: exp_taken = alu_neg;
          5: exp_taken = !alu_neg;
          default: exp_taken = 1'b0;
        endcase
        #1;
        n_tests++;
        if (redirect !== exp_taken) begin
          n_fail++; $display("FAIL taken st=%0d z=%b n=%b: got %b want %b", st, alu_zero, alu_neg, redirect, exp_taken);
        end
      end
    end
    drive_idle(); res_jump = 1; #1;
    n_tests++;
    if (redirect !== 1'b0) begin n_fail++; $display("FAIL redirect_novalid: got %b want 0", redirect); end
    drive_idle();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_stream;
    int cyc = 0;
    exp_pc_q = {}; exp_ins_q = {}; exp_addr_q = {};
    push_exp(32'h0); push_exp(32'h4);
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
    imem_ready = 1; if_ready = 1;
    while (exp_pc_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (imem_req && exp_addr_q.size() > 0) begin
        n_tests++;
        if (imem_addr !== exp_addr_q[0]) begin
          n_fail++; $display("FAIL stream_addr: got %h want %h", imem_addr, exp_addr_q[0]);
        end
        void'(exp_addr_q.pop_front());
      end
      if (if_valid) begin
        n_tests++;
        if (if_pc !== exp_pc_q[0] || if_instr !== exp_ins_q[0] || if_opcode !== exp_ins_q[0][31:26]) begin
          n_fail++; $display("FAIL stream_ir: pc=%h instr=%h op=%h want %h %h", if_pc, if_instr, if_opcode, exp_pc_q[0], exp_ins_q[0]);
        end
        void'(exp_pc_q.pop_front()); void'(exp_ins_q.pop_front());
      end
    end
    n_tests++;
    if (exp_pc_q.size() != 0) begin
      n_fail++; $display("FAIL stream_timeout: %0d outstanding want 0", exp_pc_q.size());
    end
    imem_ready = 0;
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: req=%b addr=%h valid=%b want 1 00000008 0", imem_req, imem_addr, if_valid);
      end
    end
    imem_ready = 1; if_ready = 0;
    push_exp(32'h8);
    @(negedge clk);
    imem_ready = 0;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== exp_pc_q[0] || if_instr !== exp_ins_q[0] || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_data: valid=%b pc=%h instr=%h req=%b want 1 %h %h 0", if_valid, if_pc, if_instr, imem_req, exp_pc_q[0], exp_ins_q[0]);
    end
    void'(exp_pc_q.pop_front()); void'(exp_ins_q.pop_front());
  endtask

  task automatic test_branch;
    res_valid = 1; res_branch = 1; res_branch_st = 3'd3; res_pc = 32'h10; res_imm16 = 16'hFFFC;
    alu_zero = 0; #1;
    n_tests++;
    if (redirect !== 1'b0) begin n_fail++; $display("FAIL beq_nottaken: got %b want 0", redirect); end
    alu_zero = 1; #1;
    n_tests++;
    if (redirect !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b want 1", redirect); end
    @(negedge clk);
    drive_idle();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL beq_target: req=%b addr=%h valid=%b want 1 00000004 0", imem_req, imem_addr, if_valid);
    end
    imem_ready = 1; push_exp(32'h4);
    @(negedge clk);
    imem_ready = 0;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== exp_pc_q[0] || if_instr !== exp_ins_q[0]) begin
      n_fail++; $display("FAIL beq_fetch: valid=%b pc=%h instr=%h want 1 %h %h", if_valid, if_pc, if_instr, exp_pc_q[0], exp_ins_q[0]);
    end
    void'(exp_pc_q.pop_front()); void'(exp_ins_q.pop_front());
  endtask

  task automatic test_jr_drain;
    int pulses = 0;
    if_ready = 1;
    @(negedge clk);
    if_ready = 0;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_fail++; $display("FAIL jr_pre: req=%b addr=%h want 1 00000008", imem_req, imem_addr);
    end
    res_valid = 1; res_jumpr = 1; res_rs = 32'h0040_0022; #1;
    n_tests++;
    if (redirect !== 1'b1) begin n_fail++; $display("FAIL jr_redirect: got %b want 1", redirect); end
    @(negedge clk);
    drive_idle();
    if (addr_err) pulses++;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL jr_drain: req=%b addr=%h valid=%b want 1 00000008 0", imem_req, imem_addr, if_valid);
    end
    imem_ready = 1; push_exp(32'h0040_0020);
    @(negedge clk);
    if (addr_err) pulses++;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0020 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL jr_refetch: req=%b addr=%h valid=%b want 1 00400020 0", imem_req, imem_addr, if_valid);
    end
    @(negedge clk);
    if (addr_err) pulses++;
    imem_ready = 0;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== exp_pc_q[0] || if_instr !== exp_ins_q[0]) begin
      n_fail++; $display("FAIL jr_fetch: valid=%b pc=%h instr=%h want 1 %h %h", if_valid, if_pc, if_instr, exp_pc_q[0], exp_ins_q[0]);
    end
    void'(exp_pc_q.pop_front()); void'(exp_ins_q.pop_front());
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL jr_addr_err: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_jump_full;
    res_valid = 1; res_jump = 1; res_pc = 32'hF000_0000; res_jidx = 26'h1; if_ready = 1; #1;
    n_tests++;
    if (redirect !== 1'b1) begin n_fail++; $display("FAIL j_redirect: got %b want 1", redirect); end
    @(negedge clk);
    drive_idle(); if_ready = 0;
    n_tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hF000_0004) begin
      n_fail++; $display("FAIL j_target: valid=%b req=%b addr=%h want 0 1 f0000004", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid;
    rst_n = 0;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: req=%b valid=%b want 0 0", imem_req, if_valid);
    end
    rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_restart: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_jr_drain();
    test_jump_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
